// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory port between fetch and debug, routing read data back by tag.
// Define IMEM_ARB_RR_EN for round-robin tie-breaking; otherwise debug has fixed priority.
module imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_halt,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("imem_arbiter: RD_LAT must be in 1..4");
    end
    logic              last_owner;
    logic              f_elig;
    logic              d_elig;
    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] own;
    // Grants are forced low while reset is asserted
    assign f_elig = rst & f_req & ~d_halt;
    assign d_elig = rst & d_req;
`ifdef IMEM_ARB_RR_EN
    assign d_gnt = d_elig & (~f_elig | ~last_owner);
`else
    assign d_gnt = d_elig;
`endif
    assign f_gnt    = f_elig & ~d_gnt;
    assign m_en     = f_gnt | d_gnt;
    assign m_we     = d_gnt & d_we;
    assign m_addr   = d_gnt ? d_addr : (f_gnt ? f_addr : '0);
    assign m_wdata  = d_gnt ? d_wdata : '0;
    assign f_rvalid = vld[RD_LAT-1] & ~own[RD_LAT-1];
    assign d_rvalid = vld[RD_LAT-1] & own[RD_LAT-1];
    assign f_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld        <= '0;
            own        <= '0;
            last_owner <= 1'b1;
        end else begin
            if (m_en) last_owner <= d_gnt;
            vld[0] <= m_en & ~m_we;
            own[0] <= d_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of two arbiters (RD_LAT=1 and RD_LAT=3) sharing one stimulus stream.
module tb_imem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        f_req, d_req, d_we, d_halt;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        f_gnt1, f_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1;
    logic [31:0] f_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic        f_gnt3, f_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3;
    logic [31:0] f_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p1, p3a, p3b, p3c;
    int n_cmp = 0;
    int n_bad = 0;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1), .f_rdata(f_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_halt(d_halt),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
    );
    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3), .f_rdata(f_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_halt(d_halt),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3)
    );

    // Behavioural memories with 1- and 3-cycle read latency
    always @(posedge clk) begin
        if (m_en1 && m_we1) mem1[m_addr1[7:0]] <= m_wdata1;
        p1 <= mem1[m_addr1[7:0]];
        if (m_en3 && m_we3) mem3[m_addr3[7:0]] <= m_wdata3;
        p3a <= mem3[m_addr3[7:0]];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign m_rdata1 = p1;
    assign m_rdata3 = p3c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        f_req = 0; d_req = 0; d_we = 0; d_halt = 0;
        f_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        mem1[8'h10] = 32'hDEADBEEF; mem3[8'h10] = 32'hDEADBEEF;
        mem1[8'h11] = 32'h11111111; mem3[8'h11] = 32'h11111111;
        mem1[8'h12] = 32'h22222222; mem3[8'h12] = 32'h22222222;
        mem1[8'h30] = 32'hA5A5A5A5; mem3[8'h30] = 32'hA5A5A5A5;
        idle();
        f_req = 1; d_req = 1;
        mid();
        chk("rst_fgnt", f_gnt1, 0);
        chk("rst_dgnt", d_gnt1, 0);
        chk("rst_men", m_en3, 0);
        chk("rst_mwe", m_we1, 0);
        chk("rst_rvalid", {f_rvalid1, d_rvalid1, f_rvalid3, d_rvalid3}, 0);
        nxt();
        idle();
        nxt();
        rst = 1;
        // Continuous tie straight after reset
        for (int k = 0; k < 6; k++) begin
            f_req = 1; f_addr = 32'h11; d_req = 1; d_addr = 32'h30;
            mid();
            chk($sformatf("tie%0d_d", k), d_gnt1, RR ? 32'(k % 2) : 32'd1);
            chk($sformatf("tie%0d_f", k), f_gnt1, RR ? 32'(1 - k % 2) : 32'd0);
            chk($sformatf("tie%0d_d3", k), d_gnt3, RR ? 32'(k % 2) : 32'd1);
            if (k == 0) chk("tie0_addr", m_addr1, RR ? 32'h11 : 32'h30);
            if (k == 1) chk("tie1_rv", {f_rvalid1, d_rvalid1}, RR ? 32'd2 : 32'd1);
            nxt();
        end
        idle();
        repeat (4) nxt();
        // Fetch-only read of 0x10
        f_req = 1; f_addr = 32'h10;
        mid();
        chk("fo_gnt", f_gnt1, 1);
        chk("fo_addr", m_addr1, 32'h10);
        chk("fo_we", m_we1, 0);
        nxt();
        idle();
        mid();
        chk("fo_rv1", f_rvalid1, 1);
        chk("fo_rd1", f_rdata1, 32'hDEADBEEF);
        chk("fo_drv1", d_rvalid1, 0);
        chk("fo_rv3_early", f_rvalid3, 0);
        chk("idle_addr", m_addr1, 0);
        chk("idle_wdata", m_wdata1, 0);
        chk("idle_en", m_en1, 0);
        nxt();
        mid();
        chk("fo_rv1_once", f_rvalid1, 0);
        nxt();
        mid();
        chk("fo_rv3", f_rvalid3, 1);
        chk("fo_rd3", f_rdata3, 32'hDEADBEEF);
        nxt();
        // Debug write then read-back
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        mid();
        chk("dw_gnt", d_gnt1, 1);
        chk("dw_fgnt", f_gnt1, 0);
        chk("dw_we", m_we1, 1);
        chk("dw_addr", m_addr1, 32'h20);
        chk("dw_wdata", m_wdata1, 32'h12345678);
        nxt();
        d_we = 0;
        mid();
        chk("dr_gnt", d_gnt1, 1);
        chk("dr_we", m_we1, 0);
        chk("dw_norv1", d_rvalid1, 0);
        nxt();
        idle();
        mid();
        chk("dr_rv1", d_rvalid1, 1);
        chk("dr_rd1", d_rdata1, 32'h12345678);
        chk("dr_frv1", f_rvalid1, 0);
        nxt();
        mid();
        chk("dw_norv3", d_rvalid3, 0);
        nxt();
        mid();
        chk("dr_rv3", d_rvalid3, 1);
        chk("dr_rd3", d_rdata3, 32'h12345678);
        nxt();
        // Fetch issued just before halt, then halted fetch requests
        f_req = 1; f_addr = 32'h12;
        mid();
        chk("h0_gnt", f_gnt1, 1);
        nxt();
        for (int h = 1; h <= 5; h++) begin
            d_halt = 1; f_req = 1; f_addr = 32'h13;
            mid();
            chk($sformatf("h%0d_fgnt", h), f_gnt1, 0);
            chk($sformatf("h%0d_men", h), m_en1, 0);
            if (h == 1) chk("h1_rv1", f_rvalid1, 1);
            if (h == 1) chk("h1_rd1", f_rdata1, 32'h22222222);
            if (h == 2) chk("h2_rv1", f_rvalid1, 0);
            if (h == 3) chk("h3_rv3", f_rvalid3, 1);
            if (h == 3) chk("h3_rd3", f_rdata3, 32'h22222222);
            nxt();
        end
        idle();
        // Interleaved F, D, F reads
        f_req = 1; f_addr = 32'h10;
        mid();
        nxt();
        f_req = 0; d_req = 1; d_addr = 32'h30;
        mid();
        chk("il_rv1_f0", f_rvalid1, 1);
        chk("il_rd1_f0", f_rdata1, 32'hDEADBEEF);
        nxt();
        d_req = 0; f_req = 1; f_addr = 32'h11;
        mid();
        chk("il_rv1_d", d_rvalid1, 1);
        chk("il_rd1_d", d_rdata1, 32'hA5A5A5A5);
        nxt();
        idle();
        mid();
        chk("il_rv1_f1", f_rvalid1, 1);
        chk("il_rd1_f1", f_rdata1, 32'h11111111);
        chk("il_rv3_f0", {f_rvalid3, d_rvalid3}, 32'd2);
        chk("il_rd3_f0", f_rdata3, 32'hDEADBEEF);
        nxt();
        mid();
        chk("il_rv3_d", {f_rvalid3, d_rvalid3}, 32'd1);
        chk("il_rd3_d", d_rdata3, 32'hA5A5A5A5);
        nxt();
        mid();
        chk("il_rv3_f1", {f_rvalid3, d_rvalid3}, 32'd2);
        chk("il_rd3_f1", f_rdata3, 32'h11111111);
        nxt();
        // Reset with two reads in flight
        f_req = 1; f_addr = 32'h10;
        mid();
        nxt();
        f_req = 0; d_req = 1; d_addr = 32'h30;
        mid();
        nxt();
        idle();
        f_req = 1; f_addr = 32'h12;
        rst = 0;
        mid();
        chk("mr_fgnt", f_gnt1, 0);
        chk("mr_men3", m_en3, 0);
        chk("mr_rv_a", {f_rvalid1, d_rvalid1, f_rvalid3, d_rvalid3}, 0);
        nxt();
        mid();
        chk("mr_rv_b", {f_rvalid3, d_rvalid3}, 0);
        nxt();
        rst = 1;
        mid();
        chk("mr_first_gnt", f_gnt3, 1);
        chk("mr_first_addr", m_addr3, 32'h12);
        chk("mr_rv_c", {f_rvalid3, d_rvalid3}, 0);
        nxt();
        idle();
        mid();
        chk("mr_rv1", f_rvalid1, 1);
        chk("mr_rd1", f_rdata1, 32'h22222222);
        chk("mr_rv_d", {f_rvalid3, d_rvalid3}, 0);
        nxt();
        mid();
        chk("mr_rv_e", {f_rvalid3, d_rvalid3}, 0);
        nxt();
        mid();
        chk("mr_rv3", {f_rvalid3, d_rvalid3}, 32'd2);
        chk("mr_rd3", f_rdata3, 32'h22222222);
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
